cbi980_link_ctl: RTL

Serial link sequencer for the CBI980 codec interface. Generates the bit clock (`sclk`) and frame sync (`fs`), pops one word per channel from the TX FIFOs every frame and serialises it on `sdo`, and deserialises `sdi` into one word per channel pushed to the RX FIFOs. Sits between the register/FIFO core and the pads, and reports TX underrun and RX overflow events back to the core's status flags.

---
 rtl/cbi980_link_ctl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cbi980_link_ctl.sv
// CBI980 serial link sequencer: generates sclk/fs, serialises TX FIFO words onto sdo
// and deserialises sdi into RX FIFO words, two channel slots per frame.
module cbi980_link_ctl #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             txen,
    input  logic             rxen,
    input  logic [DIV_W-1:0] sclk_half,
    input  logic [2:0]       octet_cnt,
    input  logic             rjust,
    input  logic             lsb_first,
    input  logic [31:0]      tx0_data,
    input  logic [31:0]      tx1_data,
    input  logic             tx0_valid,
    input  logic             tx1_valid,
    output logic             tx0_pop,
    output logic             tx1_pop,
    output logic [31:0]      rx0_data,
    output logic [31:0]      rx1_data,
    output logic             rx0_push,
    output logic             rx1_push,
    input  logic             rx0_full,
    input  logic             rx1_full,
    output logic [1:0]       tx_unf,
    output logic [1:0]       rx_ovf,
    output logic             sclk,
    output logic             fs,
    output logic             sdo,
    input  logic             sdi,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SLOT0, SLOT1} state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [4:0]         bit_idx;
    logic [4:0]         n_m1;
    logic               rj;
    logic               lsb;
    logic               rx_en_f;
    logic [31:0]        tx0_word;
    logic [31:0]        tx1_word;
    logic [31:0]        rx_sh;

    logic [4:0]         cfg_n_m1_c;
    logic [4:0]         load_idx_c;
    logic [4:0]         cur_idx_c;
    logic [4:0]         nxt_idx_c;
    logic [4:0]         slot_first_idx_c;
    logic [31:0]        rx_next_c;
    logic               tx_ok0_c;
    logic               tx_ok1_c;
    logic               run_c;
    logic               slot_end_c;
    logic               go_load_c;

    // Word bit index carrying field bit i, for the given field width and ordering.
    function automatic logic [4:0] field_idx(input logic [4:0] i, input logic [4:0] nm1,
                                             input logic rjf, input logic lsbf);
        logic [4:0] pos;
        pos = lsbf ? i : 5'(nm1 - i);
        return rjf ? pos : 5'(pos + 5'(5'd31 - nm1));
    endfunction

    always_comb begin
        cfg_n_m1_c = 5'd31;
        case (octet_cnt)
            3'd0, 3'd1: cfg_n_m1_c = 5'd7;
            3'd2:       cfg_n_m1_c = 5'd15;
            3'd3:       cfg_n_m1_c = 5'd23;
            default:    cfg_n_m1_c = 5'd31;
        endcase
    end

    assign load_idx_c       = field_idx(5'd0, cfg_n_m1_c, rjust, lsb_first);
    assign cur_idx_c        = field_idx(bit_idx, n_m1, rj, lsb);
    assign nxt_idx_c        = field_idx(5'(bit_idx + 5'd1), n_m1, rj, lsb);
    assign slot_first_idx_c = field_idx(5'd0, n_m1, rj, lsb);
    assign tx_ok0_c         = txen & tx0_valid;
    assign tx_ok1_c         = txen & tx1_valid;
    assign run_c            = txen | rxen;

    // Falling sclk event that closes the last bit of the current slot.
    assign slot_end_c = ((state == SLOT0) || (state == SLOT1)) && (div_cnt == sclk_half)
                        && sclk && (bit_idx == n_m1);
    assign go_load_c  = run_c && ((state == IDLE) || ((state == SLOT1) && slot_end_c));

    always_comb begin
        rx_next_c            = rx_sh;
        rx_next_c[cur_idx_c] = sdi;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_idx  <= '0;
            n_m1     <= 5'd7;
            rj       <= 1'b0;
            lsb      <= 1'b0;
            rx_en_f  <= 1'b0;
            tx0_word <= '0;
            tx1_word <= '0;
            rx_sh    <= '0;
            rx0_data <= '0;
            rx1_data <= '0;
            tx0_pop  <= 1'b0;
            tx1_pop  <= 1'b0;
            rx0_push <= 1'b0;
            rx1_push <= 1'b0;
            tx_unf   <= '0;
            rx_ovf   <= '0;
            sclk     <= 1'b0;
            fs       <= 1'b0;
            sdo      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            tx0_pop  <= 1'b0;
            tx1_pop  <= 1'b0;
            rx0_push <= 1'b0;
            rx1_push <= 1'b0;
            tx_unf   <= '0;
            rx_ovf   <= '0;

            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    sclk    <= 1'b0;
                end
                LOAD: begin
                    state   <= SLOT0;
                    div_cnt <= '0;
                    bit_idx <= '0;
                    rx_sh   <= '0;
                end
                default: begin
                    if (div_cnt == sclk_half) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (!sclk) begin
                            // Rising event: sample sdi, deliver the word after the last bit.
                            rx_sh <= rx_next_c;
                            if ((bit_idx == n_m1) && rx_en_f) begin
                                if (state == SLOT0) begin
                                    if (rx0_full) begin
                                        rx_ovf[0] <= 1'b1;
                                    end else begin
                                        rx0_push <= 1'b1;
                                        rx0_data <= rx_next_c;
                                    end
                                end else begin
                                    if (rx1_full) begin
                                        rx_ovf[1] <= 1'b1;
                                    end else begin
                                        rx1_push <= 1'b1;
                                        rx1_data <= rx_next_c;
                                    end
                                end
                            end
                        end else if (bit_idx == n_m1) begin
                            bit_idx <= '0;
                            rx_sh   <= '0;
                            if (state == SLOT0) begin
                                state <= SLOT1;
                                fs    <= 1'b1;
                                sdo   <= tx1_word[slot_first_idx_c];
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                fs    <= 1'b0;
                                sdo   <= 1'b0;
                            end
                        end else begin
                            bit_idx <= 5'(bit_idx + 5'd1);
                            sdo     <= (state == SLOT0) ? tx0_word[nxt_idx_c] : tx1_word[nxt_idx_c];
                        end
                    end else begin
                        div_cnt <= DIV_W'(div_cnt + 1'b1);
                    end
                end
            endcase

            // Frame start: latch config and TX words, first bit is driven during LOAD.
            if (go_load_c) begin
                state     <= LOAD;
                busy      <= 1'b1;
                fs        <= 1'b0;
                n_m1      <= cfg_n_m1_c;
                rj        <= rjust;
                lsb       <= lsb_first;
                rx_en_f   <= rxen;
                tx0_word  <= tx_ok0_c ? tx0_data : 32'd0;
                tx1_word  <= tx_ok1_c ? tx1_data : 32'd0;
                tx0_pop   <= tx_ok0_c;
                tx1_pop   <= tx_ok1_c;
                tx_unf[0] <= txen & ~tx0_valid;
                tx_unf[1] <= txen & ~tx1_valid;
                sdo       <= tx_ok0_c & tx0_data[load_idx_c];
            end
        end
    end

endmodule
